// File: rtl/alu_iter_exec.sv
// alu_iter_exec: execute-stage ALU, single-cycle arith/logic, iterative 1-bit/cycle shifts.
// Define KGP_ALU_FAST_SHIFT_EN to replace the iterative shifter with a barrel shifter at load.
module alu_iter_exec #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [2:0]         op,
    input  logic               shift_src,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [SHAMT_W-1:0] shamt_imm,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result,
    output logic               carry,
    output logic               zero,
    output logic               sign
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t state;
    logic [1:0] kind;
    logic [WIDTH-1:0] work, ld_work;
    logic [SHAMT_W-1:0] cnt, ld_cnt, amount;
    logic wcarry, ld_carry;
    logic [WIDTH:0] sum;
`ifdef KGP_ALU_FAST_SHIFT_EN
    logic [WIDTH:0] shl, shr, sra;
`endif
    always_comb begin
        amount   = shift_src ? b[SHAMT_W-1:0] : shamt_imm;
        sum      = {1'b0, a} + {1'b0, b};
        ld_work  = '0;
        ld_carry = 1'b0;
        ld_cnt   = '0;
`ifdef KGP_ALU_FAST_SHIFT_EN
        // extra bit on the shifted-out side captures the last bit lost
        shl = {1'b0, a} << amount;
        shr = {a, 1'b0} >> amount;
        sra = $unsigned($signed({a, 1'b0}) >>> amount);
`endif
        case (op)
            3'b000: {ld_carry, ld_work} = sum;
            3'b001: ld_work = -b;
            3'b010: ld_work = a & b;
            3'b011: ld_work = a ^ b;
`ifdef KGP_ALU_FAST_SHIFT_EN
            3'b100: {ld_carry, ld_work} = shl;
            3'b101: {ld_work, ld_carry} = shr;
            3'b110: {ld_work, ld_carry} = sra;
`else
            3'b100, 3'b101, 3'b110: begin
                ld_work = a;
                ld_cnt  = amount;
            end
`endif
            default: ld_work = '0;
        endcase
    end
    // kind: 00 shll, 01 shrl, 10 shra (low bits of the shift opcodes)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            carry  <= 1'b0;
            zero   <= 1'b1;
            sign   <= 1'b0;
            kind   <= 2'b00;
            work   <= '0;
            wcarry <= 1'b0;
            cnt    <= '0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    state  <= RUN;
                    busy   <= 1'b1;
                    kind   <= op[1:0];
                    work   <= ld_work;
                    wcarry <= ld_carry;
                    cnt    <= ld_cnt;
                end
            end else if (cnt != '0) begin
                cnt <= cnt - SHAMT_W'(1);
                case (kind)
                    2'b00:   {wcarry, work} <= {work, 1'b0};
                    2'b01:   {work, wcarry} <= {1'b0, work};
                    default: {work, wcarry} <= {work[WIDTH-1], work};
                endcase
            end else begin
                state  <= IDLE;
                busy   <= 1'b0;
                done   <= 1'b1;
                result <= work;
                carry  <= wcarry;
                zero   <= (work == '0);
                sign   <= work[WIDTH-1];
            end
        end
    end
endmodule

// File: tb/tb_alu_iter_exec.sv
// tb_alu_iter_exec: directed self-checking bench for alu_iter_exec (either shift build).
module tb_alu_iter_exec;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'b000;
    logic        shift_src = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic [4:0]  shamt_imm = '0;
    logic        busy, done, carry, zero, sign;
    logic [31:0] result;
    int n_checks = 0;
    int n_fail = 0;
    int lat;
    int seen;

    alu_iter_exec dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .shift_src(shift_src),
        .a(a), .b(b), .shamt_imm(shamt_imm), .busy(busy), .done(done),
        .result(result), .carry(carry), .zero(zero), .sign(sign)
    );

    always #5 clk = ~clk;

    function automatic int exp_lat(input int n);
`ifdef KGP_ALU_FAST_SHIFT_EN
        return 1;
`else
        return 1 + n;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic chk_out(input string tag, input logic [31:0] r, input logic c, input logic z, input logic s);
        chk({tag, "_result"}, result, r);
        chk({tag, "_carry"}, {31'd0, carry}, {31'd0, c});
        chk({tag, "_zero"}, {31'd0, zero}, {31'd0, z});
        chk({tag, "_sign"}, {31'd0, sign}, {31'd0, s});
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!done && n < 100);
    endtask

    task automatic run(input logic [2:0] o, input logic s, input logic [31:0] av, input logic [31:0] bv,
                       input logic [4:0] sh, output int n);
        op = o; shift_src = s; a = av; b = bv; shamt_imm = sh; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(n);
    endtask

    initial begin
        #23;
        chk_out("reset", 32'h0, 1'b0, 1'b1, 1'b0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        tick();
        rst = 1'b1;
        tick();

        // add overflow
        run(3'b000, 1'b0, 32'hFFFF_FFFF, 32'h1, 5'd0, lat);
        chk("add_lat", lat, 1);
        chk_out("add", 32'h0, 1'b1, 1'b1, 1'b0);
        chk("add_done_busy", {31'd0, busy}, 32'd0);

        // shra with start held high and inputs changing; then back-to-back xor in done cycle
        op = 3'b110; shift_src = 1'b0; a = 32'h8000_0000; b = 32'h0; shamt_imm = 5'd4; start = 1'b1;
        tick();
        chk("shra_busy", {31'd0, busy}, 32'd1);
        op = 3'b000; a = 32'h0000_0001; b = 32'h0000_0001; shamt_imm = 5'd9;
        wait_done(lat);
        chk("shra_lat", lat, exp_lat(4));
        chk_out("shra", 32'hF800_0000, 1'b0, 1'b0, 1'b1);
        op = 3'b011; a = 32'h1234_5678; b = 32'h1234_5678;
        tick();
        start = 1'b0;
        chk("b2b_busy", {31'd0, busy}, 32'd1);
        wait_done(lat);
        chk("xor_lat", lat, 1);
        chk_out("xor", 32'h0, 1'b0, 1'b1, 1'b0);

        // shll by register amount (shamt_imm deliberately different)
        run(3'b100, 1'b1, 32'h0000_0003, 32'd31, 5'd2, lat);
        chk("shll_lat", lat, exp_lat(31));
        chk_out("shll", 32'h8000_0000, 1'b1, 1'b0, 1'b1);

        // reset mid-shift
        op = 3'b101; shift_src = 1'b0; a = 32'hFFFF_FFFF; shamt_imm = 5'd10; start = 1'b1;
        tick();
        start = 1'b0;
        rst = 1'b0;
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk_out("rst", 32'h0, 1'b0, 1'b1, 1'b0);
        tick();
        rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done) seen++;
        end
        chk("rst_no_done", seen, 0);

        // comp
        run(3'b001, 1'b0, 32'h0, 32'd5, 5'd0, lat);
        chk("comp_lat", lat, 1);
        chk_out("comp", 32'hFFFF_FFFB, 1'b0, 1'b0, 1'b1);

        // shift by zero after a carry-setting add
        run(3'b000, 1'b0, 32'h8000_0000, 32'h8000_0001, 5'd0, lat);
        chk_out("add2", 32'h1, 1'b1, 1'b0, 1'b0);
        run(3'b100, 1'b0, 32'hA5A5_A5A5, 32'h0, 5'd0, lat);
        chk("sh0_lat", lat, 1);
        chk_out("sh0", 32'hA5A5_A5A5, 1'b0, 1'b0, 1'b1);

        // shrl by 1 with carry out, and
        run(3'b101, 1'b0, 32'h0000_0003, 32'h0, 5'd1, lat);
        chk("shrl_lat", lat, exp_lat(1));
        chk_out("shrl", 32'h1, 1'b1, 1'b0, 1'b0);
        run(3'b010, 1'b0, 32'h0000_F0F0, 32'h0000_FF00, 5'd0, lat);
        chk_out("and", 32'h0000_F000, 1'b0, 1'b0, 1'b0);

        // reserved op after carry set
        run(3'b000, 1'b0, 32'hFFFF_FFFF, 32'h2, 5'd0, lat);
        run(3'b111, 1'b0, 32'h1234_0000, 32'h5678, 5'd3, lat);
        chk("rsvd_lat", lat, 1);
        chk_out("rsvd", 32'h0, 1'b0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
